serial_crc_engine: RTL and testbench
====================================

SERIAL_CRC_ENGINE -- requirements
Module: serial_crc_engine

Interface
REQ-001 SHALL have parameter MSG_W, default 10: message length in bits.
REQ-002 SHALL have parameter CRC_W, default 8: CRC degree and remainder width.
REQ-003 SHALL have parameter POLY, default 8'h07: generator polynomial, CRC_W bits with the x^CRC_W term implicit.
REQ-004 SHALL have port clk  input  1: sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1: request a new operation; sampled only in IDLE.
REQ-007 SHALL have port mode  input  1: 0 = generate, 1 = check; sampled with start.
REQ-008 SHALL have port data_in  input  MSG_W: message, transmitted MSB first; sampled with start.
REQ-009 SHALL have port crc_in  input  CRC_W: received CRC, used in check mode only; sampled with start.
REQ-010 SHALL have port busy  output  1: high while an operation is in progress.
REQ-011 SHALL have port done  output  1: one-cycle pulse when the result is valid.
REQ-012 SHALL have port crc_out  output  CRC_W: final remainder.
REQ-013 SHALL have port codeword_out  output  MSG_W+CRC_W: {message, crc_out}.
REQ-014 SHALL have port err  output  1: check mode, remainder nonzero.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 IDLE with start=1 SHALL capture data_in, crc_in and mode, clear the LFSR to 0 and the bit counter to 0, and go to SHIFT.
REQ-017 The shifted stream SHALL be data_in followed by CRC_W trailing bits:
- generate mode: the trailing bits are zeros;
- check mode: the trailing bits are crc_in, MSB first.
REQ-018 Each SHIFT cycle SHALL consume one stream bit b, performing augmented polynomial division:
- fb = lfsr[CRC_W-1];
- lfsr = {lfsr[CRC_W-2:0], b} XOR (fb ? POLY : 0).
REQ-019 SHIFT SHALL last exactly MSG_W+CRC_W cycles, with the counter sized $clog2(MSG_W+CRC_W+1); after the last bit the FSM goes to DONE.
REQ-020 DONE SHALL last one cycle, asserting done=1, and then return to IDLE.
REQ-021 On entry to DONE, crc_out and codeword_out SHALL be loaded and SHALL hold until the next DONE or reset.
REQ-022 On entry to DONE, err SHALL be set to (mode==1 && remainder!=0) and SHALL hold like crc_out.
REQ-023 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-024 Latency: if start is sampled at edge T, busy rises after T and done is high in the cycle after edge T+MSG_W+CRC_W (cycle 19 for the defaults).
REQ-025 start while busy SHALL be ignored; it SHALL NOT be queued and SHALL NOT alter inputs already captured.
REQ-026 start held high continuously SHALL launch back-to-back operations, each one beginning on the first IDLE cycle.
REQ-027 Changes on data_in, crc_in or mode after capture SHALL NOT affect the current result.
REQ-028 A result SHALL be identical for any POLY, MSG_W>=1 and CRC_W>=2; elaboration SHALL fail for CRC_W<2 or MSG_W<1.

Reset
REQ-029 When reset=0, asynchronously and regardless of clk:
- FSM = IDLE;
- LFSR, counter, captured registers = 0;
- busy = 0, done = 0, err = 0;
- crc_out = 0, codeword_out = 0.
REQ-030 Reset asserted mid-SHIFT SHALL abort the operation: no done pulse, and the prior result is cleared.
REQ-031 After reset deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-032 Generate, defaults, data_in=10'b1010000011 -> done at cycle 19, crc_out=8'hAA, codeword_out=18'b1010000011_10101010, err=0.
REQ-033 Generate, data_in=10'b0000000001 -> crc_out=8'h07; data_in=0 -> crc_out=8'h00.
REQ-034 Check mode, data_in=10'b1010000011:
- crc_in=8'hAA -> err=0, crc_out=8'h00;
- crc_in=8'hAB -> err=1, crc_out=8'h01.
REQ-035 start pulsed at cycles 5 and 10 of an operation -> both ignored, exactly one done, result unchanged; with start held high, done pulses every 20 cycles.
REQ-036 reset=0 at cycle 8 of SHIFT -> busy and all outputs go to 0 immediately with no done; a new start with 10'b1010000011 then yields 8'hAA.
REQ-037 Parameter sweep against a reference model, 200 random messages each -> all crc_out and err match:
- MSG_W=16, CRC_W=16, POLY=16'h1021;
- MSG_W=4, CRC_W=3, POLY=3'b011.

Source files
------------

// File: rtl/serial_crc_engine.sv
// Bit-serial CRC generator/checker. The message and its trailing bits are shifted
// MSB first through an LFSR that performs augmented polynomial division.
module serial_crc_engine #(
    parameter int                 MSG_W = 10,
    parameter int                 CRC_W = 8,
    parameter logic [CRC_W-1:0]   POLY  = CRC_W'(8'h07)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mode,
    input  logic [MSG_W-1:0]         data_in,
    input  logic [CRC_W-1:0]         crc_in,
    output logic                     busy,
    output logic                     done,
    output logic [CRC_W-1:0]         crc_out,
    output logic [MSG_W+CRC_W-1:0]   codeword_out,
    output logic                     err
);

    localparam int TOTAL = MSG_W + CRC_W;
    localparam int CNT_W = $clog2(TOTAL + 1);

    generate
        if (CRC_W < 2 || MSG_W < 1) begin : g_bad_params
            $fatal(1, "serial_crc_engine: CRC_W must be >= 2 and MSG_W >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_next;
    logic [TOTAL-1:0]   stream;
    logic [MSG_W-1:0]   msg_q;
    logic               mode_q;
    logic [CRC_W-1:0]   lfsr, lfsr_next;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;

    // Remainder after consuming the stream's current head bit.
    assign lfsr_next = {lfsr[CRC_W-2:0], stream[TOTAL-1]} ^ (lfsr[CRC_W-1] ? POLY : '0);
    assign last_bit  = (cnt == CNT_W'(TOTAL - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: the default assignment first guarantees no latch is inferred on
    // paths that leave state_next untouched.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stream       <= '0;
            msg_q        <= '0;
            mode_q       <= 1'b0;
            lfsr         <= '0;
            cnt          <= '0;
            crc_out      <= '0;
            codeword_out <= '0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        msg_q  <= data_in;
                        mode_q <= mode;
                        stream <= {data_in, (mode ? crc_in : CRC_W'(0))};
                        lfsr   <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    lfsr   <= lfsr_next;
                    stream <= stream << 1;
                    cnt    <= cnt + CNT_W'(1);
                    // Results are published on the edge that enters DONE and then held.
                    if (last_bit) begin
                        crc_out      <= lfsr_next;
                        codeword_out <= {msg_q, lfsr_next};
                        err          <= mode_q && (lfsr_next != '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_crc_engine.sv
// Directed and randomized checks of serial_crc_engine in three parameterizations
// against a long-division reference model.
module tb_serial_crc_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance (MSG_W=10, CRC_W=8, POLY=8'h07)
    logic        start_d, mode_d, busy_d, done_d, err_d;
    logic [9:0]  data_d;
    logic [7:0]  crc_d, crco_d;
    logic [17:0] cw_d;

    // Sweep instance A (16/16/0x1021)
    logic        start_a, mode_a, busy_a, done_a, err_a;
    logic [15:0] data_a, crc_a, crco_a;
    logic [31:0] cw_a;

    // Sweep instance B (4/3/011)
    logic        start_b, mode_b, busy_b, done_b, err_b;
    logic [3:0]  data_b;
    logic [2:0]  crc_b, crco_b;
    logic [6:0]  cw_b;

    serial_crc_engine u_def (
        .clk(clk), .reset(reset), .start(start_d), .mode(mode_d),
        .data_in(data_d), .crc_in(crc_d), .busy(busy_d), .done(done_d),
        .crc_out(crco_d), .codeword_out(cw_d), .err(err_d)
    );

    serial_crc_engine #(.MSG_W(16), .CRC_W(16), .POLY(16'h1021)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
        .data_in(data_a), .crc_in(crc_a), .busy(busy_a), .done(done_a),
        .crc_out(crco_a), .codeword_out(cw_a), .err(err_a)
    );

    serial_crc_engine #(.MSG_W(4), .CRC_W(3), .POLY(3'b011)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
        .data_in(data_b), .crc_in(crc_b), .busy(busy_b), .done(done_b),
        .crc_out(crco_b), .codeword_out(cw_b), .err(err_b)
    );

    // Remainder of ({msg, trail}) modulo the generator x^cw + poly, by long division.
    function automatic longint unsigned crc_rem(input longint unsigned msg,
                                                input longint unsigned trail,
                                                input int mw, input int cw,
                                                input longint unsigned poly);
        longint unsigned v;
        longint unsigned g;
        v = (msg << cw) | trail;
        g = (64'd1 << cw) | poly;
        for (int i = mw + cw - 1; i >= cw; i--)
            if (v[i]) v = v ^ (g << (i - cw));
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each run task starts 1 time unit after an edge with the DUT idle and returns
    // in the DONE cycle (or after the cycle budget runs out).
    task automatic run_def(input logic m, input logic [9:0] d, input logic [7:0] c, output int lat);
        mode_d = m; data_d = d; crc_d = c; start_d = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0;
        lat = 0;
        while (!done_d && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run_a(input logic m, input logic [15:0] d, input logic [15:0] c, output int lat);
        mode_a = m; data_a = d; crc_a = c; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        lat = 0;
        while (!done_a && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run_b(input logic m, input logic [3:0] d, input logic [2:0] c, output int lat);
        mode_b = m; data_b = d; crc_b = c; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        lat = 0;
        while (!done_b && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int dones;
        int cyc;
        int t_done[3];
        logic [7:0]  got_d;
        logic [15:0] ra;
        logic [2:0]  rb;
        logic [9:0]  dd;
        logic [15:0] da, ca;
        logic [3:0]  db;
        logic [2:0]  cb;
        logic        mm;
        longint unsigned exp_r;

        reset = 1'b0;
        start_d = 0; mode_d = 0; data_d = '0; crc_d = '0;
        start_a = 0; mode_a = 0; data_a = '0; crc_a = '0;
        start_b = 0; mode_b = 0; data_b = '0; crc_b = '0;
        #1;
        check("reset_busy",  64'(busy_d), 64'd0);
        check("reset_done",  64'(done_d), 64'd0);
        check("reset_crc",   64'(crco_d), 64'd0);
        check("reset_cw",    64'(cw_d),   64'd0);
        check("reset_err",   64'(err_d),  64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Generate, first start right after reset release
        run_def(1'b0, 10'b1010000011, 8'h00, lat);
        check("gen_latency", 64'(lat), 64'd18);
        check("gen_crc",     64'(crco_d), 64'hAA);
        check("gen_cw",      64'(cw_d),   64'(18'b1010000011_10101010));
        check("gen_err",     64'(err_d),  64'd0);
        check("done_busy",   64'(busy_d), 64'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done_d), 64'd0);
        check("idle_busy",      64'(busy_d), 64'd0);
        check("crc_hold",       64'(crco_d), 64'hAA);

        run_def(1'b0, 10'b0000000001, 8'h00, lat);
        check("gen_one_crc", 64'(crco_d), 64'h07);
        @(posedge clk); #1;
        run_def(1'b0, 10'b0000000000, 8'h00, lat);
        check("gen_zero_crc", 64'(crco_d), 64'h00);
        @(posedge clk); #1;

        // Check mode
        run_def(1'b1, 10'b1010000011, 8'hAA, lat);
        check("chk_ok_err", 64'(err_d),  64'd0);
        check("chk_ok_crc", 64'(crco_d), 64'h00);
        @(posedge clk); #1;
        run_def(1'b1, 10'b1010000011, 8'hAB, lat);
        check("chk_bad_err", 64'(err_d),  64'd1);
        check("chk_bad_crc", 64'(crco_d), 64'h01);
        check("err_hold_pre", 64'(err_d), 64'd1);
        @(posedge clk); #1;

        // Start pulses while busy and input changes after capture are ignored
        mode_d = 1'b0; data_d = 10'b1010000011; crc_d = 8'h5C; start_d = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0;
        dones = 0; got_d = '0;
        for (int k = 1; k <= 40; k++) begin
            start_d = (k == 5 || k == 10);
            data_d  = 10'($urandom);
            crc_d   = 8'($urandom);
            mode_d  = 1'($urandom);
            if (done_d) begin dones++; got_d = crco_d; end
            @(posedge clk); #1;
        end
        start_d = 1'b0;
        check("busy_start_dones", 64'(dones), 64'd1);
        check("busy_start_crc",   64'(got_d), 64'hAA);

        // Start held high: back-to-back operations every 20 cycles
        mode_d = 1'b0; data_d = 10'b0110011010; start_d = 1'b1;
        exp_r = crc_rem(64'(10'b0110011010), 0, 10, 8, 64'h07);
        dones = 0; cyc = 0;
        t_done = '{default: 0};
        while (dones < 3 && cyc < 80) begin
            @(posedge clk); #1; cyc++;
            if (done_d) begin
                check("held_crc", 64'(crco_d), exp_r);
                t_done[dones] = cyc;
                dones++;
            end
        end
        start_d = 1'b0;
        check("held_dones",   64'(dones), 64'd3);
        check("held_period1", 64'(t_done[1] - t_done[0]), 64'd20);
        check("held_period2", 64'(t_done[2] - t_done[1]), 64'd20);
        for (int k = 0; k < 25; k++) begin @(posedge clk); #1; end

        // Establish a nonzero prior result, then abort mid-SHIFT with reset
        run_def(1'b0, 10'b1010000011, 8'h00, lat);
        @(posedge clk); #1;
        mode_d = 1'b1; data_d = 10'h3C5; crc_d = 8'h11; start_d = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0;
        for (int k = 0; k < 7; k++) begin @(posedge clk); #1; end
        #3 reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy_d), 64'd0);
        check("abort_done", 64'(done_d), 64'd0);
        check("abort_crc",  64'(crco_d), 64'd0);
        check("abort_cw",   64'(cw_d),   64'd0);
        check("abort_err",  64'(err_d),  64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done_d) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_def(1'b0, 10'b1010000011, 8'h00, lat);
        check("after_abort_lat", 64'(lat),    64'd18);
        check("after_abort_crc", 64'(crco_d), 64'hAA);
        @(posedge clk); #1;

        // Random default-parameter operations
        for (int n = 0; n < 40; n++) begin
            dd = 10'($urandom);
            mm = 1'($urandom);
            got_d = 8'($urandom);
            if (mm && n[0]) got_d = 8'(crc_rem(64'(dd), 0, 10, 8, 64'h07));
            exp_r = crc_rem(64'(dd), mm ? 64'(got_d) : 64'd0, 10, 8, 64'h07);
            run_def(mm, dd, got_d, lat);
            check("rnd_def_lat", 64'(lat),    64'd18);
            check("rnd_def_crc", 64'(crco_d), exp_r);
            check("rnd_def_cw",  64'(cw_d),   64'({dd, 8'(exp_r)}));
            check("rnd_def_err", 64'(err_d),  64'(mm && exp_r != 0));
            @(posedge clk); #1;
        end

        // Sweep A: MSG_W=16, CRC_W=16, POLY=0x1021
        for (int n = 0; n < 200; n++) begin
            da = 16'($urandom);
            mm = 1'($urandom);
            ca = 16'($urandom);
            if (mm && n[0]) ca = 16'(crc_rem(64'(da), 0, 16, 16, 64'h1021));
            exp_r = crc_rem(64'(da), mm ? 64'(ca) : 64'd0, 16, 16, 64'h1021);
            run_a(mm, da, ca, lat);
            ra = crco_a;
            check("sweep_a_lat", 64'(lat), 64'd32);
            check("sweep_a_crc", 64'(ra), exp_r);
            check("sweep_a_err", 64'(err_a), 64'(mm && exp_r != 0));
            @(posedge clk); #1;
        end

        // Sweep B: MSG_W=4, CRC_W=3, POLY=3'b011
        for (int n = 0; n < 200; n++) begin
            db = 4'($urandom);
            mm = 1'($urandom);
            cb = 3'($urandom);
            if (mm && n[0]) cb = 3'(crc_rem(64'(db), 0, 4, 3, 64'h3));
            exp_r = crc_rem(64'(db), mm ? 64'(cb) : 64'd0, 4, 3, 64'h3);
            run_b(mm, db, cb, lat);
            rb = crco_b;
            check("sweep_b_lat", 64'(lat), 64'd7);
            check("sweep_b_crc", 64'(rb), exp_r);
            check("sweep_b_err", 64'(err_b), 64'(mm && exp_r != 0));
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
